// File: rtl/c2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : c2_pkg
// Purpose  : Shared types and constants for the C2 UART TX scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package c2_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } c2_tx_state_e;

  localparam int C2_NUM_REQ_DEFAULT     = 3;
  localparam int C2_WDOG_CYCLES_DEFAULT = 1_000_000;

  localparam int REQ_LOADER = 0;
  localparam int REQ_DEBUG  = 1;
  localparam int REQ_DUMPER = 2;

endpackage
`default_nettype wire

// File: rtl/c2_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : c2_tx_scheduler_if
// Purpose  : Requester byte handshake plus UART transmitter handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface c2_tx_scheduler_if
  import c2_pkg::*;
#(
  parameter int NUM_REQ = C2_NUM_REQ_DEFAULT
);

  logic [NUM_REQ-1:0]   req_valid_i;
  logic [8*NUM_REQ-1:0] req_data_i;
  logic [NUM_REQ-1:0]   req_last_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic [7:0]           uart_tx_data_o;
  logic                 uart_tx_start_o;
  logic                 uart_tx_done_i;

  // Scheduler side
  modport slave (
    input  req_valid_i, req_data_i, req_last_i, uart_tx_done_i,
    output req_ready_o, uart_tx_data_o, uart_tx_start_o
  );

  // Requesters and UART side
  modport master (
    output req_valid_i, req_data_i, req_last_i, uart_tx_done_i,
    input  req_ready_o, uart_tx_data_o, uart_tx_start_o
  );

endinterface
`default_nettype wire

// File: rtl/c2_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : c2_rr_picker
// Purpose  : Combinational cyclic priority search starting after rr_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module c2_rr_picker
  import c2_pkg::*;
#(
  parameter int NUM_REQ = C2_NUM_REQ_DEFAULT,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [PTR_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_winner,
  output logic               o_any
);

  int   w_idx;
  logic w_found;

  always_comb begin
    o_winner = '0;
    w_idx    = 0;
    w_found  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = (int'(i_rr_ptr) + i) % NUM_REQ;
      if (!w_found && i_valid[w_idx]) begin
        o_winner[w_idx] = 1'b1;
        w_found         = 1'b1;
      end
    end
  end

  assign o_any = |i_valid;

endmodule
`default_nettype wire

// File: rtl/c2_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : c2_tx_scheduler
// Purpose  : Frame-granular round-robin arbiter feeding one UART transmitter.
//            Define C2_TX_WATCHDOG_EN to release stalled frames after
//            WDOG_CYCLES idle cycles in S_HOLD.
// Revision : 1.0 - initial release
// ============================================================================
module c2_tx_scheduler
  import c2_pkg::*;
#(
  parameter int NUM_REQ     = C2_NUM_REQ_DEFAULT,
  parameter int WDOG_CYCLES = C2_WDOG_CYCLES_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  c2_tx_scheduler_if.slave     bus,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 abort_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("c2_tx_scheduler: NUM_REQ must be within 2..8");
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("c2_tx_scheduler: WDOG_CYCLES must be at least 1");
  end

  c2_tx_state_e       r_state, w_next_state;
  logic [PTR_W-1:0]   r_rr_ptr, r_owner, w_win_idx, w_sel_idx;
  logic [NUM_REQ-1:0] w_win, w_ready, r_grant;
  logic               w_any, w_accept, w_wdog_hit, r_last, w_sel_last;
  logic [7:0]         r_data, w_sel_data;

  c2_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_valid  (bus.req_valid_i),
    .i_rr_ptr (r_rr_ptr),
    .o_winner (w_win),
    .o_any    (w_any)
  );

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win[i]) w_win_idx = PTR_W'(i);
    end
  end

  // The owner's lane feeds the latch in S_HOLD; the fresh winner otherwise.
  assign w_sel_idx = (r_state == S_HOLD) ? r_owner : w_win_idx;

  always_comb begin
    w_sel_data = 8'h00;
    w_sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == w_sel_idx) begin
        w_sel_data = bus.req_data_i[8*i +: 8];
        w_sel_last = bus.req_last_i[i];
      end
    end
  end

  assign w_accept = |(bus.req_valid_i & w_ready);

`ifdef C2_TX_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] r_wdog_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wdog_cnt <= '0;
    end else if (r_state == S_WAIT && bus.uart_tx_done_i && !r_last) begin
      r_wdog_cnt <= '0;
    end else if (r_state == S_HOLD && !w_accept && !w_wdog_hit) begin
      r_wdog_cnt <= r_wdog_cnt + 1'b1;
    end
  end

  assign w_wdog_hit = (r_state == S_HOLD) && !w_accept &&
                      (r_wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
  assign w_wdog_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next_state = S_START;
      S_START: w_next_state = S_WAIT;
      S_WAIT:  if (bus.uart_tx_done_i) w_next_state = r_last ? S_IDLE : S_HOLD;
      S_HOLD: begin
        if (w_accept)        w_next_state = S_START;
        else if (w_wdog_hit) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Ready is gated by rst_ni so the IDLE winner cannot leak out during reset.
  always_comb begin
    w_ready = '0;
    case (r_state)
      S_IDLE:  w_ready = w_win;
      S_HOLD:  w_ready = r_grant;
      default: w_ready = '0;
    endcase
    if (!rst_ni) w_ready = '0;
  end

  assign bus.req_ready_o     = w_ready;
  assign bus.uart_tx_start_o = (r_state == S_START);
  assign bus.uart_tx_data_o  = r_data;
  assign grant_o             = r_grant;
  assign busy_o              = (r_state != S_IDLE);
  assign abort_o             = w_wdog_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data   <= 8'h00;
      r_last   <= 1'b0;
      r_grant  <= '0;
      r_owner  <= '0;
      r_rr_ptr <= PTR_W'(NUM_REQ - 1);
    end else begin
      if (w_accept) begin
        r_data <= w_sel_data;
        r_last <= w_sel_last;
      end
      if (r_state == S_IDLE && w_accept) begin
        r_grant <= w_win;
        r_owner <= w_win_idx;
      end
      if ((r_state == S_WAIT && bus.uart_tx_done_i && r_last) || w_wdog_hit) begin
        r_grant  <= '0;
        r_rr_ptr <= r_owner;
      end
    end
  end

endmodule
`default_nettype wire
